cnn_frame_sequencer: RTL and testbench



---
 rtl/cnn_ctrl_pkg.sv | 18 +
 rtl/cnn_frame_sequencer_raster_addr_gen.sv | 48 ++++
 rtl/cnn_frame_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared types and constants for the digit-CNN frame sequencer.
// Holds the sequencer state encoding, the pixel ink levels and the default CNN input size.
package cnn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP,
    WAIT
  } seq_state_t;

  localparam logic [7:0] PIX_ON  = 8'hFF;
  localparam logic [7:0] PIX_OFF = 8'h00;

  localparam int CNN_IMG_W = 28;
  localparam int CNN_IMG_H = 28;

endpackage

// File: rtl/cnn_frame_sequencer_raster_addr_gen.sv
// Raster-order (x, y) address generator for the cropped CNN window.
// Asserting clear and advance together steps straight to the pixel after the origin.
module raster_addr_gen
  import cnn_ctrl_pkg::*;
#(
  parameter  int IMG_W = CNN_IMG_W,
  parameter  int IMG_H = CNN_IMG_H,
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] base_x;
  logic [YW-1:0] base_y;

  always_comb begin
    base_x = clear ? '0 : x;
    base_y = clear ? '0 : y;
  end

  assign last = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (base_x == XW'(IMG_W - 1)) begin
        x <= '0;
        y <= (base_y == YW'(IMG_H - 1)) ? '0 : base_y + 1'b1;
      end else begin
        x <= base_x + 1'b1;
        y <= base_y;
      end
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end
  end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Snapshots the canvas, streams a cropped window to CNN_top and latches the digit or a timeout.
// Optional canvas-idle auto trigger is built when CNN_AUTO_TRIGGER_EN is defined.
module cnn_frame_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int CANVAS_W         = 30,
  parameter int CANVAS_H         = 30,
  parameter int IMG_W            = CNN_IMG_W,
  parameter int IMG_H            = CNN_IMG_H,
  parameter int X_OFF            = 1,
  parameter int Y_OFF            = 1,
  parameter int PIXEL_GAP        = 0,
  parameter int TIMEOUT_CYCLES   = 65535,
  parameter int AUTO_IDLE_CYCLES = 25000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [CANVAS_W*CANVAS_H-1:0] i_canvas,
  output logic [7:0]                   o_pixel,
  output logic                         o_pixel_valid,
  input  logic [3:0]                   i_digit,
  input  logic                         i_digit_valid,
  output logic [3:0]                   o_digit,
  output logic                         o_digit_valid,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int NBITS        = CANVAS_W * CANVAS_H;
  localparam int XW           = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW           = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GAP_W        = ($clog2(PIXEL_GAP + 1) > 0) ? $clog2(PIXEL_GAP + 1) : 1;
  localparam int TO_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W        = $clog2(NBITS);
  localparam int FIRST_IDX    = Y_OFF * CANVAS_W + X_OFF;
  localparam bit SINGLE_PIXEL = (IMG_W * IMG_H == 1);

  if (X_OFF + IMG_W > CANVAS_W || Y_OFF + IMG_H > CANVAS_H ||
      TIMEOUT_CYCLES < 1 || AUTO_IDLE_CYCLES < 1) begin : g_param_check
    $error("cnn_frame_sequencer: crop window or cycle parameters out of range");
  end

  seq_state_t        state;
  logic [NBITS-1:0]  snap;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              sent_all;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              last;
  logic              start_req;
  logic              accept;
  logic              advance;
  logic [IDX_W-1:0]  pix_sel;

  assign accept  = (state == IDLE) && start_req;
  assign advance = accept || (state == STREAM);
  assign pix_sel = IDX_W'((32'(y) + 32'(Y_OFF)) * 32'(CANVAS_W) + 32'(x) + 32'(X_OFF));

  raster_addr_gen #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .advance(advance),
    .x      (x),
    .y      (y),
    .last   (last)
  );

`ifdef CNN_AUTO_TRIGGER_EN
  localparam int ST_W = $clog2(AUTO_IDLE_CYCLES + 1);

  logic [NBITS-1:0] prev_canvas;
  logic [ST_W-1:0]  stable_cnt;
  logic             auto_fired;
  logic             canvas_changed;
  logic             auto_start;

  assign canvas_changed = (i_canvas != prev_canvas);
  assign auto_start     = !auto_fired && (|i_canvas) && (stable_cnt == ST_W'(AUTO_IDLE_CYCLES));
  assign start_req      = i_start || auto_start;

  // Any accepted start consumes the current stable canvas; only a new drawing re-arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_canvas <= '0;
      stable_cnt  <= '0;
      auto_fired  <= 1'b0;
    end else begin
      prev_canvas <= i_canvas;
      if (canvas_changed) begin
        stable_cnt <= '0;
        auto_fired <= 1'b0;
      end else begin
        if (stable_cnt != ST_W'(AUTO_IDLE_CYCLES)) begin
          stable_cnt <= stable_cnt + 1'b1;
        end
        if (accept) begin
          auto_fired <= 1'b1;
        end
      end
    end
  end
`else
  assign start_req = i_start;
`endif

  function automatic seq_state_t after_pixel(input logic was_last);
    if (PIXEL_GAP > 0) return GAP;
    else if (was_last) return WAIT;
    else return STREAM;
  endfunction

  // The first pixel comes straight from i_canvas so it is on the bus the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      snap          <= '0;
      gap_cnt       <= '0;
      to_cnt        <= '0;
      sent_all      <= 1'b0;
      o_pixel       <= PIX_OFF;
      o_pixel_valid <= 1'b0;
      o_digit       <= 4'd0;
      o_digit_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      o_pixel_valid <= 1'b0;
      o_digit_valid <= 1'b0;
      o_timeout     <= 1'b0;
      case (state)
        IDLE: begin
          gap_cnt  <= '0;
          to_cnt   <= '0;
          sent_all <= 1'b0;
          if (accept) begin
            snap          <= i_canvas;
            o_pixel       <= i_canvas[FIRST_IDX] ? PIX_ON : PIX_OFF;
            o_pixel_valid <= 1'b1;
            o_busy        <= 1'b1;
            sent_all      <= SINGLE_PIXEL;
            state         <= after_pixel(SINGLE_PIXEL);
          end
        end
        STREAM: begin
          o_pixel       <= snap[pix_sel] ? PIX_ON : PIX_OFF;
          o_pixel_valid <= 1'b1;
          sent_all      <= last;
          state         <= after_pixel(last);
        end
        GAP: begin
          if (gap_cnt == GAP_W'(PIXEL_GAP - 1)) begin
            gap_cnt <= '0;
            state   <= sent_all ? WAIT : STREAM;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (i_digit_valid) begin
            o_digit       <= i_digit;
            o_digit_valid <= 1'b1;
            o_busy        <= 1'b0;
            state         <= IDLE;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: one gapless/long-timeout instance and one
// PIXEL_GAP=2 / TIMEOUT_CYCLES=50 instance, expected cycle numbers worked out by hand.
module tb_cnn_frame_sequencer;
  import cnn_ctrl_pkg::*;

  localparam int NB = 900;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start0, dvalid0, start1, dvalid1;
  logic [NB-1:0] canvas0, canvas1;
  logic [3:0]    digit0, digit1;
  logic [7:0]    pix0, pix1;
  logic          pv0, pv1, dv0, dv1, busy0, busy1, to0, to1;
  logic [3:0]    dig0, dig1;

  int errors = 0;
  int checks = 0;
  int cnt, ones, first_n, last_n, prev_n, spacing_bad, busy_drops, dv_seen, to_seen, to_n;
  logic [7:0] first_pix;
  logic [3:0] dig_before;
  logic       busy_at;

  cnn_frame_sequencer #(.PIXEL_GAP(0), .TIMEOUT_CYCLES(150), .AUTO_IDLE_CYCLES(20)) d0 (
    .clk(clk), .rst(rst), .i_start(start0), .i_canvas(canvas0),
    .o_pixel(pix0), .o_pixel_valid(pv0), .i_digit(digit0), .i_digit_valid(dvalid0),
    .o_digit(dig0), .o_digit_valid(dv0), .o_busy(busy0), .o_timeout(to0)
  );

  cnn_frame_sequencer #(.PIXEL_GAP(2), .TIMEOUT_CYCLES(50), .AUTO_IDLE_CYCLES(20)) d1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_canvas(canvas1),
    .o_pixel(pix1), .o_pixel_valid(pv1), .i_digit(digit1), .i_digit_valid(dvalid1),
    .o_digit(dig1), .o_digit_valid(dv1), .o_busy(busy1), .o_timeout(to1)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cnt = 0; ones = 0; first_n = 0; last_n = 0; prev_n = 0; spacing_bad = 0;
    busy_drops = 0; dv_seen = 0; to_seen = 0; to_n = 0;
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; dvalid0 = 1'b0; digit0 = 4'd0; canvas0 = '0;
    start1 = 1'b0; dvalid1 = 1'b0; digit1 = 4'd0; canvas1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_pixel", 32'(pix0), 32'(0));
    check_output("reset_pixel_valid", 32'(pv0), 32'(0));
    check_output("reset_digit", 32'(dig0), 32'(0));
    check_output("reset_digit_valid", 32'(dv0), 32'(0));
    check_output("reset_busy", 32'(busy0), 32'(0));
    check_output("reset_timeout", 32'(to0), 32'(0));

    // Single ink bit at canvas (1,1) = crop origin; stray start/digit/canvas edits mid-stream.
    $display("[TB] single-pixel stream, mid-stream disturbances, digit 7 in WAIT");
    canvas0 = '0;
    canvas0[31] = 1'b1;
    start0 = 1'b1;
    clear_stats();
    for (int n = 1; n <= 885; n++) begin
      @(negedge clk);
      if (pv0) begin
        cnt++;
        last_n = n;
        if (first_n == 0) first_n = n;
        if (pix0 != PIX_OFF) ones++;
      end
      if (n == 1) first_pix = pix0;
      if (!busy0) busy_drops++;
      if (dv0) dv_seen++;
      if (to0) to_seen++;
      if (n == 884) dig_before = dig0;
      start0 = (n == 300);
      if (n == 1 || n == 301) canvas0 = '0;
      if (n == 300) canvas0 = '1;
      dvalid0 = (n == 300) || (n == 885);
      digit0 = (n == 300) ? 4'd3 : 4'd7;
    end
    check_output("first_valid_cycle", 32'(first_n), 32'(1));
    check_output("first_pixel", 32'(first_pix), 32'(8'hFF));
    check_output("pixel_count", 32'(cnt), 32'(784));
    check_output("ink_pixels", 32'(ones), 32'(1));
    check_output("last_valid_cycle", 32'(last_n), 32'(784));
    check_output("busy_drops", 32'(busy_drops), 32'(0));
    check_output("stray_digit_valid", 32'(dv_seen), 32'(0));
    check_output("stray_digit_value", 32'(dig_before), 32'(0));
    check_output("no_timeout", 32'(to_seen), 32'(0));
    @(negedge clk);
    dvalid0 = 1'b0;
    check_output("digit_valid_pulse", 32'(dv0), 32'(1));
    check_output("digit_value", 32'(dig0), 32'(7));
    check_output("busy_fall_with_digit", 32'(busy0), 32'(0));
    check_output("timeout_with_digit", 32'(to0), 32'(0));
    @(negedge clk);
    check_output("digit_valid_single", 32'(dv0), 32'(0));
    check_output("digit_held", 32'(dig0), 32'(7));

    // Blank canvas, no digit: last pixel 784, WAIT from 784, counter hits 150 in cycle 934.
    $display("[TB] blank canvas timeout, restart, reset at pixel 400");
    canvas0 = '0;
    start0 = 1'b1;
    clear_stats();
    busy_at = 1'b1;
    for (int n = 1; n <= 934; n++) begin
      @(negedge clk);
      if (pv0) begin
        cnt++;
        if (pix0 != PIX_OFF) ones++;
      end
      if (n < 934 && !busy0) busy_drops++;
      if (to0) begin
        to_seen++;
        to_n = n;
      end
      if (n == 934) busy_at = busy0;
      start0 = (n == 934);
    end
    check_output("blank_pixel_count", 32'(cnt), 32'(784));
    check_output("blank_ink_pixels", 32'(ones), 32'(0));
    check_output("timeout_count", 32'(to_seen), 32'(1));
    check_output("timeout_cycle", 32'(to_n), 32'(934));
    check_output("busy_before_timeout", 32'(busy_drops), 32'(0));
    check_output("busy_at_timeout", 32'(busy_at), 32'(0));
    check_output("digit_kept_on_timeout", 32'(dig0), 32'(7));
    @(negedge clk);
    start0 = 1'b0;
    check_output("restart_valid", 32'(pv0), 32'(1));
    check_output("restart_busy", 32'(busy0), 32'(1));
    cnt = 1;
    for (int m = 2; m <= 400; m++) begin
      @(negedge clk);
      if (pv0) cnt++;
    end
    check_output("valids_before_reset", 32'(cnt), 32'(400));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("reset_mid_valid", 32'(pv0), 32'(0));
    check_output("reset_mid_busy", 32'(busy0), 32'(0));
    check_output("reset_mid_digit", 32'(dig0), 32'(0));

    // Full ink with PIXEL_GAP=2: valids at 1,4,...,2350, WAIT from 2352, timeout in 2402.
    $display("[TB] gapped full-ink stream and 50-cycle timeout");
    canvas1 = '1;
    start1 = 1'b1;
    clear_stats();
    busy_at = 1'b1;
    for (int n = 1; n <= 2403; n++) begin
      @(negedge clk);
      if (pv1) begin
        cnt++;
        last_n = n;
        if (pix1 == PIX_ON) ones++;
        if (prev_n == 0) first_n = n;
        else if (n - prev_n != 3) spacing_bad++;
        prev_n = n;
      end
      if (n < 2402 && !busy1) busy_drops++;
      if (to1) begin
        to_seen++;
        to_n = n;
      end
      if (n == 2402) busy_at = busy1;
      start1 = 1'b0;
      if (n == 1) canvas1 = '0;
    end
    check_output("gap_first_valid", 32'(first_n), 32'(1));
    check_output("gap_pixel_count", 32'(cnt), 32'(784));
    check_output("gap_ink_pixels", 32'(ones), 32'(784));
    check_output("gap_spacing", 32'(spacing_bad), 32'(0));
    check_output("gap_last_valid", 32'(last_n), 32'(2350));
    check_output("gap_busy_held", 32'(busy_drops), 32'(0));
    check_output("gap_timeout_count", 32'(to_seen), 32'(1));
    check_output("gap_timeout_cycle", 32'(to_n), 32'(2402));
    check_output("gap_busy_at_timeout", 32'(busy_at), 32'(0));
    check_output("gap_digit_unchanged", 32'(dig1), 32'(0));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check_output("gap_restart_busy", 32'(busy1), 32'(1));
    check_output("gap_restart_valid", 32'(pv1), 32'(1));

`ifdef CNN_AUTO_TRIGGER_EN
    $display("[TB] auto trigger on a stable inked canvas");
    canvas0 = '0;
    canvas0[100] = 1'b1;
    cnt = 0;
    busy_at = busy0;
    for (int n = 1; n <= 1400; n++) begin
      @(negedge clk);
      if (busy0 && !busy_at) cnt++;
      busy_at = busy0;
    end
    check_output("auto_start_count", 32'(cnt), 32'(1));
    check_output("auto_idle_after", 32'(busy0), 32'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
